serial_add16: RTL and testbench
===============================

SERIAL_ADD16 -- requirements
Module: serial_add16

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 Port: a  input  16  first operand; sampled only on an accepted start.
REQ-006 Port: b  input  16  second operand; sampled only on an accepted start.
REQ-007 Port: cin  input  1  carry-in; sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking a valid new result.
REQ-010 Port: sum  output  16  registered result a+b+cin, modulo 2^16.
REQ-011 Port: cout  output  1  carry out of bit 15.
REQ-012 Port: ovf  output  1  signed overflow: carry into bit 15 XOR carry out of bit 15.
REQ-013 Port: zr  output  1  high when sum equals 0x0000.
REQ-014 Port: ng  output  1  high when sum[15] is 1.

Function
REQ-015 Addition is bit-serial, LSB first, one bit per clock, through exactly one 1-bit full-add cell and one carry flip-flop.
REQ-016 FSM states: IDLE, ADD, DONE; encoding is free.
REQ-017 start is accepted when busy=0, i.e. in state IDLE or DONE.
REQ-018 An accepted start at edge E0 latches a, b and cin into internal shift/carry registers, clears the bit counter, and moves the FSM to ADD.
REQ-019 In ADD, edges E1..E16 process bits 0..15 in order; the counter is 4 bits and wraps 15->0 on the final bit.
REQ-020 At edge E16 the FSM moves to DONE and sum, cout, ovf, zr and ng are loaded together.
REQ-021 done=1 for exactly the cycle after E16 (state DONE), so latency from the accepting edge to done is 16 cycles.
REQ-022 busy=1 exactly while the FSM is in ADD.
REQ-023 From DONE, the FSM moves to IDLE on the next edge, or to ADD if start=1 on that edge; back-to-back operations therefore take 17 cycles each.
REQ-024 start while busy=1 is ignored: no operand capture and no effect on the operation in progress.
REQ-025 sum, cout, ovf, zr and ng hold their values from the DONE load until the next DONE load and never show partial results.
REQ-026 Operand inputs may change freely after the accepting edge without affecting the result.

Reset
REQ-027 rst_n=0 immediately forces: FSM to IDLE, busy=0, done=0, sum=0x0000, cout=0, ovf=0, zr=0, ng=0, counter=0, carry flip-flop=0, shift registers=0.
REQ-028 Reset during ADD aborts the operation and produces no done pulse.
REQ-029 The first start accepted after rst_n deasserts behaves exactly as in REQ-018.

Structure
REQ-030 WIDTH, the counter width (4) and the FSM state encodings are defined in the shared Hack_chip constants include, not locally.
REQ-031 The 1-bit add is one instance of the existing FullAdder sub-module (a, b, c -> sum, carry); no other arithmetic operator is used for the data path.
REQ-032 The carry into bit 15 is captured at bit 15 for the ovf computation.

Verification
REQ-033 Reset, then start with a=0x0001, b=0x0001, cin=0 -> done 16 cycles after the accepting edge; sum=0x0002, cout=0, ovf=0, zr=0, ng=0.
REQ-034 Start with a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zr=1, ng=0.
REQ-035 Start with a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1, ng=1, zr=0.
REQ-036 Start with a=0x1234, b=0x1111, then pulse start at cycle 5 with a=0xFFFF, b=0xFFFF -> second start ignored; single done with sum=0x2345.
REQ-037 Start with a=0xAAAA, b=0x5555; assert rst_n=0 after 8 bits -> busy=0 and all outputs 0 immediately, no done; after release, 0x0003+0x0004 -> sum=0x0007.
REQ-038 Hold start=1 continuously with a=0x8000, b=0x8000 -> done every 17 cycles with sum=0x0000, cout=1, ovf=1, zr=1.

Source files
------------

// File: rtl/serial_add16_pkg.sv
// Shared constants for the bit-serial 16-bit adder.
// Holds the datapath width, counter width and FSM state encodings.
package serial_add16_pkg;

    localparam int SA_WIDTH = 16;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add16_fa.sv
// One-bit full-add cell used by the serial adder datapath.
// Pure combinational: sum and carry out of a, b and carry-in c.
module serial_add16_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add16.sv
// Bit-serial 16-bit adder: one bit per clock, LSB first, through a single
// full-add cell and carry flip-flop; flags load together on completion.
module serial_add16
    import serial_add16_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zr,
    output logic             ng
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_next;

    serial_add16_fa u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the top so the result lands LSB-aligned after 16 shifts
    assign sum_next = {fa_sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zr      <= 1'b0;
            ng      <= 1'b0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sh_a    <= '0;
            sh_b    <= '0;
            acc     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a    <= a;
                        sh_b    <= b;
                        carry_q <= cin;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    acc     <= sum_next;
                    carry_q <= fa_carry;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry_q here is the carry into the sign bit
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= sum_next;
                        cout  <= fa_carry;
                        ovf   <= carry_q ^ fa_carry;
                        zr    <= (sum_next == '0);
                        ng    <= fa_sum;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add16.sv
// Self-checking bench for serial_add16: vector table plus corner sequences,
// with a scoreboard queue checked whenever done pulses.
module tb_serial_add16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zr;
        logic        ng;
    } vec_t;

    typedef struct {
        vec_t v;
        int   e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zr;
    logic        ng;

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    int   dones  = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];

    serial_add16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zr    (zr),
        .ng    (ng)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c);
        vec_t        v;
        logic [16:0] s;
        s      = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v.a    = x;
        v.b    = y;
        v.cin  = c;
        v.sum  = s[15:0];
        v.cout = s[16];
        v.ovf  = (x[15] == y[15]) && (s[15] != x[15]);
        v.zr   = (s[15:0] == 16'h0000);
        v.ng   = s[15];
        return v;
    endfunction

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y,
                                input logic c, input logic [15:0] s,
                                input logic co, input logic ov,
                                input logic z, input logic n);
        vec_t v;
        v.a = x; v.b = y; v.cin = c; v.sum = s;
        v.cout = co; v.ovf = ov; v.zr = z; v.ng = n;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending operation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none, sum=%0h", sum);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", edges - mon_e.e0, 16);
                chk("sum", {16'd0, sum}, {16'd0, mon_e.v.sum});
                chk("cout", {31'd0, cout}, {31'd0, mon_e.v.cout});
                chk("ovf", {31'd0, ovf}, {31'd0, mon_e.v.ovf});
                chk("zr", {31'd0, zr}, {31'd0, mon_e.v.zr});
                chk("ng", {31'd0, ng}, {31'd0, mon_e.v.ng});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
            sb.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        int   n = 0;
        exp_t e;
        @(posedge clk);
        #1;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        @(posedge clk);
        #1;
        e.v  = v;
        e.e0 = edges;
        sb.push_back(e);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_drain("op");
        #1;
        chk("hold_sum", {16'd0, sum}, {16'd0, v.sum});
    endtask

    initial begin
        int   d0;
        int   n;
        int   prev_e0;
        exp_t e;
        vec_t v8;

        tbl[0] = mk(16'h0001, 16'h0001, 1'b0, 16'h0002, 0, 0, 0, 0);
        tbl[1] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
        tbl[2] = mk(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 0, 1, 0, 1);
        tbl[3] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 1, 1, 0);
        tbl[4] = mk(16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0, 0);
        tbl[5] = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1, 0, 0, 1);
        tbl[6] = mk(16'h0003, 16'h0004, 1'b0, 16'h0007, 0, 0, 0, 0);
        tbl[7] = mk(16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1, 0, 1, 0);
        for (int i = 8; i < 14; i++)
            tbl[i] = model(16'($urandom), 16'($urandom), 1'($urandom));

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {28'd0, cout, ovf, zr, ng}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(tbl[i]);

        // Start while busy must be ignored
        @(posedge clk);
        #1;
        d0    = dones;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h1111;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        e.v  = tbl[4];
        e.e0 = edges;
        sb.push_back(e);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_hold_prev", {16'd0, sum}, {16'd0, tbl[13].sum});
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("ign");
        repeat (20) @(posedge clk);
        chk("ign_single_done", dones - d0, 1);

        // Reset in the middle of an addition
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        e.v  = model(16'hAAAA, 16'h5555, 1'b0);
        e.e0 = edges;
        sb.push_back(e);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_flags", {28'd0, cout, ovf, zr, ng}, 32'd0);
        sb.delete();
        d0 = dones;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("abort_no_done", dones - d0, 0);
        run_op(tbl[6]);

        // Start held high: back-to-back operations every 17 cycles
        v8 = tbl[3];
        @(posedge clk);
        #1;
        d0      = dones;
        prev_e0 = 0;
        start   = 1'b1;
        a       = v8.a;
        b       = v8.b;
        cin     = v8.cin;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (busy !== 1'b0 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            #1;
            e.v  = v8;
            e.e0 = edges;
            sb.push_back(e);
            if (k > 0)
                chk("b2b_spacing", edges - prev_e0, 17);
            prev_e0 = edges;
        end
        start = 1'b0;
        wait_drain("b2b");
        repeat (5) @(posedge clk);
        chk("b2b_done_count", dones - d0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule
